vedic_mult_pipe: RTL and testbench



---
 rtl/vedic_mult_pipe.sv | 212 +++++++++++++++++++++
 tb/tb_vedic_mult_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vedic_mult_pipe.sv
// vedic_mult_pipe
//   Pipelined unsigned Urdhva-Tiryakbhyam (Vedic) multiplier with valid/ready
//   handshaking and an optional multiply-accumulate path.
//   Operands are split into four half-width partial products. Each one is
//   built by recursive Vedic decomposition down to 2x2 cells. The products
//   are then combined over three registered stages. Latency is 3 cycles and
//   throughput is one beat per cycle. One global advance enable either
//   shifts every stage or holds every stage.
//
// Compile-time option:
//   VEDIC_MAC_EN  when defined, adds the accumulator, sticky overflow and the
//                 in_acc/in_clr behaviour. When undefined, every beat returns
//                 its plain product and out_ovf is tied to 0.
//
// Parameters:
//   WIDTH    operand width, power of two, 4..32
//   GUARD_W  accumulator guard bits above 2*WIDTH, 0..16
//   OUT_W    result width, 2*WIDTH + GUARD_W
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b          unsigned operands
//   in_acc, in_clr      MAC beat / start new accumulation
//   out_valid/out_ready result handshake
//   out_p               product or accumulated sum, zero-extended
//   out_ovf             sticky accumulator overflow
module vedic_mult_pipe #(
  parameter int WIDTH   = 8,
  parameter int GUARD_W = 8,
  localparam int OUT_W  = 2*WIDTH + GUARD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_acc,
  input  logic             in_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_p,
  output logic             out_ovf
);

  localparam int HW = WIDTH/2;
  localparam int PW = 2*WIDTH;

  function automatic logic [OUT_W:0] acc_add(input logic [OUT_W-1:0] a,
                                             input logic [OUT_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  logic             adv;
  logic             vld_p0, vld_p1, vld_p2;
  logic [WIDTH-1:0] ll_c, hl_c, lh_c, hh_c;
  logic [WIDTH-1:0] ll_p0, hl_p0, lh_p0, hh_p0;
  logic [WIDTH-1:0] ll_p1, hh_p1;
  logic [WIDTH:0]   x_c, x_p1;
  logic [PW-1:0]    prod_c;
  logic [OUT_W-1:0] prod_ext;
  logic [OUT_W-1:0] res_c;
  logic [OUT_W-1:0] p_p2;

  // The output register is the only one that can refuse a beat, so its
  // occupancy alone gates the whole pipe (bubbles are not squeezed out).
  assign adv       = !vld_p2 || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2;
  assign out_p     = p_p2;

  vedic_core #(.N(HW)) u_ll (.a(in_a[HW-1:0]),     .b(in_b[HW-1:0]),     .p(ll_c));
  vedic_core #(.N(HW)) u_hl (.a(in_a[WIDTH-1:HW]), .b(in_b[HW-1:0]),     .p(hl_c));
  vedic_core #(.N(HW)) u_lh (.a(in_a[HW-1:0]),     .b(in_b[WIDTH-1:HW]), .p(lh_c));
  vedic_core #(.N(HW)) u_hh (.a(in_a[WIDTH-1:HW]), .b(in_b[WIDTH-1:HW]), .p(hh_c));

  // ---- Stage 1: half-width partial products ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_p0 <= 1'b0;
    else if (adv) vld_p0 <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      ll_p0 <= ll_c;
      hl_p0 <= hl_c;
      lh_p0 <= lh_c;
      hh_p0 <= hh_c;
    end
  end

  // ---- Stage 2: cross-term sum ----
  assign x_c = {1'b0, hl_p0} + {1'b0, lh_p0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      vld_p1 <= 1'b0;
    else if (adv) vld_p1 <= vld_p0;
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      ll_p1 <= ll_p0;
      x_p1  <= x_c;
      hh_p1 <= hh_p0;
    end
  end

  // ---- Stage 3: final product, optional accumulate, output register ----
  assign prod_c   = PW'(ll_p1) + (PW'(x_p1) << HW) + {hh_p1, {WIDTH{1'b0}}};
  assign prod_ext = OUT_W'(prod_c);

`ifdef VEDIC_MAC_EN
  logic             acc_p0, clr_p0, acc_p1, clr_p1;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d, ovf_res_c, ovf_p2;
  logic [OUT_W:0]   sum_c;

  always_ff @(posedge clk) begin
    if (adv) begin
      acc_p0 <= in_acc;
      clr_p0 <= in_clr;
      acc_p1 <= acc_p0;
      clr_p1 <= clr_p0;
    end
  end

  assign sum_c = acc_add(acc_q, prod_ext);

  // Plain beats report the current sticky flag without touching it.
  always_comb begin
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    res_c     = prod_ext;
    ovf_res_c = ovf_q;
    if (vld_p1 && acc_p1) begin
      if (clr_p1) begin
        acc_d = prod_ext;
        ovf_d = 1'b0;
      end else begin
        acc_d = sum_c[OUT_W-1:0];
        ovf_d = ovf_q | sum_c[OUT_W];
      end
      res_c     = acc_d;
      ovf_res_c = ovf_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q  <= '0;
      ovf_q  <= 1'b0;
      ovf_p2 <= 1'b0;
    end else if (adv) begin
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      ovf_p2 <= ovf_res_c;
    end
  end

  assign out_ovf = ovf_p2;
`else
  logic unused_mac;
  assign unused_mac = in_acc ^ in_clr;
  assign res_c      = prod_ext;
  assign out_ovf    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      p_p2   <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      p_p2   <= res_c;
    end
  end

endmodule

// vedic_core
//   Combinational NxN unsigned Vedic multiplier. It splits recursively into
//   four N/2 products until it reaches the 2x2 vertical-crosswise cell.
//   Ports: a, b operands [N-1:0]; p product [2N-1:0].
module vedic_core #(
  parameter int N = 4
) (
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p
);

  localparam int H   = N/2;
  localparam int P_W = 2*N;

  if (N == 2) begin : g_cell
    logic c1;
    assign p[0]       = a[0] & b[0];
    assign {c1, p[1]} = {1'b0, a[1] & b[0]} + {1'b0, a[0] & b[1]};
    assign p[3:2]     = {1'b0, a[1] & b[1]} + {1'b0, c1};
  end else begin : g_split
    logic [N-1:0] ll, hl, lh, hh;
    logic [N:0]   x;
    vedic_core #(.N(H)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(ll));
    vedic_core #(.N(H)) u_hl (.a(a[N-1:H]), .b(b[H-1:0]), .p(hl));
    vedic_core #(.N(H)) u_lh (.a(a[H-1:0]), .b(b[N-1:H]), .p(lh));
    vedic_core #(.N(H)) u_hh (.a(a[N-1:H]), .b(b[N-1:H]), .p(hh));
    assign x = {1'b0, hl} + {1'b0, lh};
    assign p = P_W'(ll) + (P_W'(x) << H) + {hh, {N{1'b0}}};
  end

endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed bench for vedic_mult_pipe (WIDTH=8, GUARD_W=1 so that OUT_W=17).
// MAC expectations depend on whether VEDIC_MAC_EN is defined.
module tb_vedic_mult_pipe;

  localparam int WIDTH   = 8;
  localparam int GUARD_W = 1;
  localparam int OUT_W   = 2*WIDTH + GUARD_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             in_acc, in_clr;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_p;
  logic             out_ovf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] va [8];
  logic [WIDTH-1:0] vb [8];
  logic             vacc [8];
  logic             vclr [8];
  logic [OUT_W-1:0] ep [8];
  logic             eo [8];

  vedic_mult_pipe #(.WIDTH(WIDTH), .GUARD_W(GUARD_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .in_clr(in_clr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_p(out_p), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int i, input int a, input int b, input logic acc,
                          input logic clr, input int p, input logic o);
    va[i]   = WIDTH'(a);
    vb[i]   = WIDTH'(b);
    vacc[i] = acc;
    vclr[i] = clr;
    ep[i]   = OUT_W'(p);
    eo[i]   = o;
  endtask

  // Streams n table beats at full rate with out_ready held high.
  // Each result is expected exactly three edges after its acceptance.
  task automatic run_beats(input string tag, input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        in_valid = 1'b1;
        in_a = va[i]; in_b = vb[i]; in_acc = vacc[i]; in_clr = vclr[i];
      end else begin
        in_valid = 1'b0; in_acc = 1'b0; in_clr = 1'b0;
      end
      tick();
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      if (i >= 2) begin
        check($sformatf("%s_valid%0d", tag, i-2), 32'(out_valid), 32'd1);
        check($sformatf("%s_p%0d", tag, i-2), 32'(out_p), 32'(ep[i-2]));
        check($sformatf("%s_ovf%0d", tag, i-2), 32'(out_ovf), 32'(eo[i-2]));
      end
    end
    tick();
    check({tag, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_acc = 1'b0; in_clr = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_p",     32'(out_p),     32'd0);
    check("rst_out_ovf",   32'(out_ovf),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    tick();

    // Single beat 255*255: out_valid appears on the third edge after acceptance.
    in_valid = 1'b1; in_a = 8'd255; in_b = 8'd255;
    tick();
    in_valid = 1'b0;
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    check("lat_e3_p",     32'(out_p),     32'hFE01);
    check("lat_e3_ovf",   32'(out_ovf),   32'd0);
    tick();
    check("lat_consumed", 32'(out_valid), 32'd0);

    // Full-rate streaming.
    set_beat(0, 3, 5, 0, 0, 15, 0);
    set_beat(1, 16, 16, 0, 0, 256, 0);
    set_beat(2, 0, 200, 0, 0, 0, 0);
    set_beat(3, 128, 2, 0, 0, 256, 0);
    run_beats("stream", 4);

    // Backpressure: two beats in flight, output stalled for 5 cycles.
    in_valid = 1'b1; in_a = 8'd10; in_b = 8'd10;
    tick();
    in_a = 8'd20; in_b = 8'd3;
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_first_valid", 32'(out_valid), 32'd1);
    check("bp_first_p",     32'(out_p),     32'd100);
    out_ready = 1'b0;
    in_valid = 1'b1; in_a = 8'd99; in_b = 8'd99;
    #1;
    check("bp_in_ready_low", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("bp_hold_valid%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_hold_p%0d", k),     32'(out_p),     32'd100);
      check($sformatf("bp_hold_rdy%0d", k),   32'(in_ready),  32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_second_valid", 32'(out_valid), 32'd1);
    check("bp_second_p",     32'(out_p),     32'd60);
    tick();
    check("bp_no_dup", 32'(out_valid), 32'd0);
    tick();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Multiply-accumulate sequence.
`ifdef VEDIC_MAC_EN
    set_beat(0, 3, 4, 1, 1, 12, 0);
    set_beat(1, 5, 6, 1, 0, 42, 0);
    set_beat(2, 7, 7, 0, 0, 49, 0);
    set_beat(3, 1, 1, 1, 0, 43, 0);
`else
    set_beat(0, 3, 4, 1, 1, 12, 0);
    set_beat(1, 5, 6, 1, 0, 30, 0);
    set_beat(2, 7, 7, 0, 0, 49, 0);
    set_beat(3, 1, 1, 1, 0, 1, 0);
`endif
    run_beats("mac", 4);

    // Accumulator wrap at 17 bits, sticky flag, cleared by a new accumulation.
`ifdef VEDIC_MAC_EN
    set_beat(0, 255, 255, 1, 1, 65025, 0);
    set_beat(1, 255, 255, 1, 0, 130050, 0);
    set_beat(2, 255, 255, 1, 0, 64003, 1);
    set_beat(3, 2, 2, 0, 0, 4, 1);
    set_beat(4, 1, 1, 1, 1, 1, 0);
`else
    set_beat(0, 255, 255, 1, 1, 65025, 0);
    set_beat(1, 255, 255, 1, 0, 65025, 0);
    set_beat(2, 255, 255, 1, 0, 65025, 0);
    set_beat(3, 2, 2, 0, 0, 4, 0);
    set_beat(4, 1, 1, 1, 1, 1, 0);
`endif
    run_beats("ovf", 5);

    // Reset with three MAC beats in flight.
    out_ready = 1'b1;
    in_valid = 1'b1; in_acc = 1'b1; in_clr = 1'b0;
    in_a = 8'd9; in_b = 8'd9;
    tick();
    in_a = 8'd8; in_b = 8'd8;
    tick();
    in_a = 8'd7; in_b = 8'd7;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    in_valid = 1'b0; in_acc = 1'b0;
    #1;
    check("midrst_valid",    32'(out_valid), 32'd0);
    check("midrst_p",        32'(out_p),     32'd0);
    check("midrst_in_ready", 32'(in_ready),  32'd1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("post_rst_idle%0d", k), 32'(out_valid), 32'd0);
    end
    set_beat(0, 2, 3, 1, 0, 6, 0);
    run_beats("post_rst_mac", 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
